// File: rtl/riscv_pd_rsbq.sv
// riscv_pd_rsbq: pre-decode stage with static branch prediction, circular return-stack buffer and programmable CSR-write stall.
// Optional: define RV12_PD_RSB_FLUSH_CLEAR_EN to invalidate the RSB on st_flush_i.
module riscv_pd_rsbq #(
  parameter int              XLEN             = 32,
  parameter logic [XLEN-1:0] PC_INIT          = 'h200,
  parameter int              HAS_RVC          = 0,
  parameter int              HAS_BPU          = 0,
  parameter int              RSB_DEPTH        = 4,
  parameter int              CSR_STALL_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_stall_i,
  input  logic            du_mode_i,
  input  logic            bu_flush_i,
  input  logic            st_flush_i,
  input  logic [XLEN-1:0] bu_nxt_pc_i,
  input  logic [XLEN-1:0] st_nxt_pc_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [31:0]     if_instr_i,
  input  logic            if_bubble_i,
  input  logic [1:0]      bp_predict_i,
  output logic            pd_stall_o,
  output logic            pd_flush_o,
  output logic [XLEN-1:0] pd_pc_o,
  output logic [31:0]     pd_instr_o,
  output logic            pd_bubble_o,
  output logic [1:0]      pd_bp_predict_o,
  output logic [XLEN-1:0] pd_rsb_pc_o,
  output logic [XLEN-1:0] pd_nxt_pc_o,
  output logic            pd_latch_nxt_pc_o
);
  localparam bit              HAS_RSB = RSB_DEPTH != 0;
  localparam int              D       = HAS_RSB ? RSB_DEPTH : 2;
  localparam int              PW      = $clog2(D);
  localparam int              CW      = $clog2(D + 1);
  localparam logic [XLEN-1:0] MASK    = HAS_RVC != 0 ? ~XLEN'(1) : ~XLEN'(3);
`ifdef RV12_PD_RSB_FLUSH_CLEAR_EN
  localparam bit FLUSH_CLR = 1'b1;
`else
  localparam bit FLUSH_CLR = 1'b0;
`endif

  logic [6:0]      opc;
  logic [4:0]      rd, rs1;
  logic [2:0]      f3;
  logic            valid, is_jal, is_jalr, is_br, rd_l, rs1_l;
  logic            push, pop, repl, csr_trig, taken, upd, we;
  logic [XLEN-1:0] imm_uj, imm_sb, link_pc, rsb_top;
  logic [1:0]      pred;
  logic [XLEN-1:0] mem_q [2**PW];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      scnt_q, scnt_d;
  logic            stalled_q, stalled_d;
  logic [XLEN-1:0] pd_pc_q, pd_pc_d, pd_rsb_pc_q, pd_rsb_pc_d;
  logic [31:0]     pd_instr_q, pd_instr_d;
  logic            pd_bubble_q, pd_bubble_d;
  logic [1:0]      pd_bp_q, pd_bp_d;

  assign opc      = if_instr_i[6:0];
  assign rd       = if_instr_i[11:7];
  assign rs1      = if_instr_i[19:15];
  assign f3       = if_instr_i[14:12];
  assign valid    = ~if_bubble_i & ~du_mode_i;
  assign is_jal   = valid & (opc == 7'b1101111);
  assign is_jalr  = valid & (opc == 7'b1100111);
  assign is_br    = valid & (opc == 7'b1100011);
  assign rd_l     = (rd == 5'd1) | (rd == 5'd5);
  assign rs1_l    = (rs1 == 5'd1) | (rs1 == 5'd5);
  // JAL has no rs1, so it can only push
  assign push     = (is_jal & rd_l) | (is_jalr & rd_l & (~rs1_l | (rs1 == rd)));
  assign pop      = is_jalr & rs1_l & ~rd_l;
  assign repl     = is_jalr & rd_l & rs1_l & (rs1 != rd);
  assign csr_trig = ~if_bubble_i & (opc == 7'b1110011) & ((f3[1:0] == 2'b01) | (f3[1] & (rs1 != 5'd0)));

  assign imm_uj  = {{(XLEN-20){if_instr_i[31]}}, if_instr_i[19:12], if_instr_i[20], if_instr_i[30:21], 1'b0};
  assign imm_sb  = {{(XLEN-12){if_instr_i[31]}}, if_instr_i[7], if_instr_i[30:25], if_instr_i[11:8], 1'b0};
  assign link_pc = if_pc_i + ((HAS_RVC != 0 && if_instr_i[1:0] != 2'b11) ? XLEN'(2) : XLEN'(4));
  assign rsb_top = mem_q[ptr_q];

  assign taken = is_jal | (is_br & (HAS_BPU != 0 ? bp_predict_i[1] : if_instr_i[31]))
               | (HAS_RSB & (pop | repl) & (cnt_q != '0));
  assign pred  = is_jal ? 2'b10 : is_br ? (HAS_BPU != 0 ? bp_predict_i : {if_instr_i[31], 1'b0}) : 2'b00;

  assign pd_flush_o        = bu_flush_i | st_flush_i;
  assign pd_stall_o        = id_stall_i | (scnt_q != 4'd0);
  assign pd_nxt_pc_o       = is_jal ? if_pc_i + imm_uj : is_br ? if_pc_i + imm_sb : rsb_top;
  assign pd_latch_nxt_pc_o = taken & ~stalled_q & ~pd_flush_o;
  assign upd               = HAS_RSB & ~pd_stall_o & ~pd_flush_o;

  always_comb begin
    pd_pc_d     = st_flush_i ? st_nxt_pc_i & MASK : bu_flush_i ? bu_nxt_pc_i & MASK : pd_stall_o ? pd_pc_q : if_pc_i & MASK;
    pd_instr_d  = id_stall_i ? pd_instr_q : if_instr_i;
    pd_bubble_d = pd_flush_o ? 1'b1 : id_stall_i ? pd_bubble_q : (scnt_q != 4'd0) | if_bubble_i;
    pd_bp_d     = id_stall_i ? pd_bp_q : pred;
    pd_rsb_pc_d = pd_stall_o ? pd_rsb_pc_q : HAS_RSB ? rsb_top : '0;
    scnt_d      = pd_flush_o ? 4'd0 : id_stall_i ? scnt_q : scnt_q != 4'd0 ? scnt_q - 4'd1
                : csr_trig ? 4'(CSR_STALL_CYCLES) : 4'd0;
    stalled_d   = taken & id_stall_i;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    we          = 1'b0;
    if (upd && push) begin
      ptr_d = ptr_q + PW'(1);
      cnt_d = cnt_q == CW'(D) ? cnt_q : cnt_q + CW'(1);
      we    = 1'b1;
    end else if (upd && pop && cnt_q != '0) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else if (upd && repl) begin
      cnt_d = cnt_q == '0 ? CW'(1) : cnt_q;
      we    = 1'b1;
    end
    if (FLUSH_CLR && st_flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pd_pc_q     <= PC_INIT & MASK;
      pd_instr_q  <= 32'h0000_0013;
      pd_bubble_q <= 1'b1;
      pd_bp_q     <= 2'b00;
      pd_rsb_pc_q <= '0;
      scnt_q      <= 4'd0;
      stalled_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      pd_pc_q     <= pd_pc_d;
      pd_instr_q  <= pd_instr_d;
      pd_bubble_q <= pd_bubble_d;
      pd_bp_q     <= pd_bp_d;
      pd_rsb_pc_q <= pd_rsb_pc_d;
      scnt_q      <= scnt_d;
      stalled_q   <= stalled_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // push writes the new slot, replace rewrites the current top; ptr_d addresses both
  always_ff @(posedge clk_i) begin
    if (we) mem_q[ptr_d] <= link_pc;
  end

  assign pd_pc_o         = pd_pc_q;
  assign pd_instr_o      = pd_instr_q;
  assign pd_bubble_o     = pd_bubble_q;
  assign pd_bp_predict_o = pd_bp_q;
  assign pd_rsb_pc_o     = pd_rsb_pc_q;
endmodule

// File: tb/tb_riscv_pd_rsbq.sv
// tb_riscv_pd_rsbq: directed and randomized checks of the pre-decode stage against a queue-based reference model.
module tb_riscv_pd_rsbq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_stall = 0, du = 0, bu_fl = 0, st_fl = 0, if_bub = 1;
  logic [31:0] bu_npc = 0, st_npc = 0, if_pc = 32'h200, if_instr = 32'h13;
  logic [1:0]  bp = 0;
  logic        pd_stall, pd_flush, pd_bubble, pd_latch;
  logic [31:0] pd_pc, pd_instr, pd_rsb_pc, pd_nxt_pc;
  logic [1:0]  pd_bp;

  riscv_pd_rsbq #(.XLEN(32), .PC_INIT(32'h200), .HAS_RVC(0), .HAS_BPU(0), .RSB_DEPTH(4), .CSR_STALL_CYCLES(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_stall_i(id_stall), .du_mode_i(du), .bu_flush_i(bu_fl), .st_flush_i(st_fl),
    .bu_nxt_pc_i(bu_npc), .st_nxt_pc_i(st_npc), .if_pc_i(if_pc), .if_instr_i(if_instr), .if_bubble_i(if_bub),
    .bp_predict_i(bp), .pd_stall_o(pd_stall), .pd_flush_o(pd_flush), .pd_pc_o(pd_pc), .pd_instr_o(pd_instr),
    .pd_bubble_o(pd_bubble), .pd_bp_predict_o(pd_bp), .pd_rsb_pc_o(pd_rsb_pc), .pd_nxt_pc_o(pd_nxt_pc),
    .pd_latch_nxt_pc_o(pd_latch));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [31:0] m_pc, m_instr, m_rsbpc;
  logic        m_bub, m_rsbv, m_stalled;
  logic [1:0]  m_bp;
  int          m_cnt;
  logic [31:0] rsb[$];
  logic        last_stall, last_latch;
  logic [31:0] last_nxt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h67};
  endfunction
  function automatic logic [31:0] enc_br(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, 5'd0, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_csr(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rd, input logic [11:0] csr);
    return {csr, rs1, f3, rd, 7'h73};
  endfunction

  task automatic model_reset();
    m_pc = 32'h200; m_instr = 32'h13; m_bub = 1; m_bp = 0; m_rsbpc = 0; m_rsbv = 1;
    m_cnt = 0; m_stalled = 0; rsb.delete();
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    logic        flush, stall_o, valid, jal, jalr, br, rdl, rsl, taken, trig;
    logic [31:0] tgt, uj, sb, link;
    logic [1:0]  pred;
    logic [4:0]  rd, rs1;
    logic [2:0]  f3;
    logic [6:0]  opc;
    int          act;
    #1;
    opc = if_instr[6:0]; rd = if_instr[11:7]; rs1 = if_instr[19:15]; f3 = if_instr[14:12];
    flush   = bu_fl | st_fl;
    stall_o = id_stall | (m_cnt != 0);
    valid   = !if_bub && !du;
    jal = valid && opc == 7'h6F; jalr = valid && opc == 7'h67; br = valid && opc == 7'h63;
    rdl = rd == 1 || rd == 5; rsl = rs1 == 1 || rs1 == 5;
    act = (jal && rdl) ? 1 : 0;
    if (jalr) act = (rdl && rsl) ? (rs1 == rd ? 1 : 3) : rdl ? 1 : rsl ? 2 : 0;
    uj   = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    sb   = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    link = if_pc + 4;
    taken = jal || (br && if_instr[31]) || ((act == 2 || act == 3) && rsb.size() > 0);
    tgt   = jal ? if_pc + uj : br ? if_pc + sb : (rsb.size() > 0 ? rsb[$] : 32'h0);
    pred  = (jal || (br && if_instr[31])) ? 2'b10 : 2'b00;
    trig  = !if_bub && opc == 7'h73 && (f3 == 1 || f3 == 5 || (f3 inside {2, 3, 6, 7} && rs1 != 0));
    chk("stall", pd_stall, stall_o);
    chk("flush", pd_flush, flush);
    chk("latch", pd_latch, taken && !m_stalled && !flush);
    if (taken) chk("nxt_pc", pd_nxt_pc, tgt);
    last_stall = pd_stall; last_latch = pd_latch; last_nxt = pd_nxt_pc;
    if (!stall_o) begin
      m_rsbv = rsb.size() > 0;
      if (m_rsbv) m_rsbpc = rsb[$];
    end
    m_pc  = st_fl ? st_npc & 32'hFFFF_FFFC : bu_fl ? bu_npc & 32'hFFFF_FFFC : !stall_o ? if_pc & 32'hFFFF_FFFC : m_pc;
    m_bub = flush ? 1'b1 : id_stall ? m_bub : (m_cnt != 0 ? 1'b1 : if_bub);
    if (!id_stall) begin
      m_instr = if_instr;
      m_bp = pred;
    end
    m_cnt = flush ? 0 : id_stall ? m_cnt : m_cnt != 0 ? m_cnt - 1 : trig ? 3 : 0;
    m_stalled = taken && id_stall;
    if (!stall_o && !flush) begin
      if (act == 1) begin
        rsb.push_back(link);
        if (rsb.size() > 4) void'(rsb.pop_front());
      end else if (act == 2 && rsb.size() > 0) void'(rsb.pop_back());
      else if (act == 3) begin
        if (rsb.size() == 0) rsb.push_back(link);
        else rsb[rsb.size() - 1] = link;
      end
    end
`ifdef RV12_PD_RSB_FLUSH_CLEAR_EN
    if (st_fl) rsb.delete();
`endif
    @(posedge clk);
    #1;
    chk("pd_pc", pd_pc, m_pc);
    chk("pd_instr", pd_instr, m_instr);
    chk("pd_bubble", pd_bubble, m_bub);
    chk("pd_bp", pd_bp, m_bp);
    if (m_rsbv) chk("pd_rsb_pc", pd_rsb_pc, m_rsbpc);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    if_pc = pc; if_instr = ins; if_bub = 0; id_stall = 0; du = 0; bu_fl = 0; st_fl = 0;
    step();
  endtask

  function automatic logic [4:0] pick_reg();
    int s;
    s = $urandom_range(0, 3);
    return s == 0 ? 5'd0 : s == 1 ? 5'd1 : s == 2 ? 5'd5 : 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_cycle();
    int s;
    logic [31:0] imm;
    s = $urandom_range(0, 5);
    imm = $urandom;
    if_pc = $urandom & 32'hFFFF_FFFC;
    case (s)
      0: if_instr = enc_jal(pick_reg(), imm);
      1: if_instr = enc_jalr(pick_reg(), pick_reg(), imm[11:0]);
      2: if_instr = enc_br(imm[12:0], imm[16:14]);
      3: if_instr = enc_csr(3'($urandom_range(0, 7)), $urandom_range(0, 1) != 0 ? 5'd0 : 5'($urandom), 5'd3, 12'h300);
      4: if_instr = 32'h13;
      default: if_instr = $urandom;
    endcase
    if_bub = $urandom_range(0, 7) == 0; id_stall = $urandom_range(0, 4) == 0; du = $urandom_range(0, 15) == 0;
    bu_fl = $urandom_range(0, 19) == 0; st_fl = $urandom_range(0, 19) == 0;
    bu_npc = $urandom; st_npc = $urandom; bp = 2'($urandom);
    step();
  endtask

  initial begin
    int sc, pulses;
    model_reset();
    #12;
    chk("rst_pc", pd_pc, 32'h200);
    chk("rst_instr", pd_instr, 32'h13);
    chk("rst_bubble", pd_bubble, 1'b1);
    chk("rst_bp", pd_bp, 2'b00);
    chk("rst_rsb_pc", pd_rsb_pc, 32'h0);
    chk("rst_latch", pd_latch, 1'b0);
    @(negedge clk);
    rst_n = 1;
    step();
    // CSR write stall
    drive(32'h300, enc_csr(3'b001, 5'd5, 5'd0, 12'h300));
    sc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h304, 32'h13);
      sc += int'(last_stall);
    end
    chk("csr_stall_cycles", sc, 3);
    drive(32'h308, enc_csr(3'b010, 5'd0, 5'd3, 12'h300));
    drive(32'h30C, 32'h13);
    chk("csrrs_x0_no_stall", last_stall, 1'b0);
    // call / return
    drive(32'h1000, enc_jal(5'd1, 32'h40));
    drive(32'h1040, enc_jalr(5'd0, 5'd1, 12'h0));
    chk("ret_taken", last_latch, 1'b1);
    chk("ret_target", last_nxt, 32'h1004);
    drive(32'h1044, enc_jalr(5'd0, 5'd1, 12'h0));
    chk("ret_empty", last_latch, 1'b0);
    // nested calls overflow the 4-deep RSB
    for (int k = 0; k < 6; k++) drive(32'h3000 + k * 256, enc_jal(5'd1, 32'h100));
    for (int k = 0; k < 6; k++) begin
      drive(32'h4000 + k * 4, enc_jalr(5'd0, 5'd1, 12'h0));
      if (k < 4) chk("nest_ret_target", last_nxt, 32'h3004 + (5 - k) * 256);
      chk("nest_ret_taken", last_latch, k < 4);
    end
    // BTFN branches
    drive(32'h2000, enc_br(13'h1FF8, 3'b000));
    chk("beq_back_target", last_nxt, 32'h1FF8);
    chk("beq_back_taken", last_latch, 1'b1);
    chk("beq_back_pred", pd_bp, 2'b10);
    drive(32'h2004, enc_br(13'h0008, 3'b000));
    chk("beq_fwd_taken", last_latch, 1'b0);
    chk("beq_fwd_pred", pd_bp, 2'b00);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if_pc = 32'h2000; if_instr = enc_br(13'h1FF8, 3'b000); if_bub = 0; id_stall = i < 3;
      step();
      pulses += int'(last_latch);
    end
    chk("strobe_once", pulses, 1);
    // simultaneous flushes
    drive(32'h5000, enc_jal(5'd1, 32'h100));
    drive(32'h5100, enc_csr(3'b101, 5'd7, 5'd0, 12'h300));
    drive(32'h5104, 32'h13);
    if_pc = 32'h5104; st_fl = 1; bu_fl = 1; st_npc = 32'h80; bu_npc = 32'h400;
    step();
    chk("flush_pc", pd_pc, 32'h80);
    chk("flush_bubble", pd_bubble, 1'b1);
    drive(32'h80, 32'h13);
    chk("flush_cnt_clear", last_stall, 1'b0);
    drive(32'h84, enc_jalr(5'd0, 5'd1, 12'h0));
`ifdef RV12_PD_RSB_FLUSH_CLEAR_EN
    chk("ret_after_flush", last_latch, 1'b0);
`else
    chk("ret_after_flush", last_latch, 1'b1);
    chk("ret_after_flush_tgt", last_nxt, 32'h5004);
`endif
    for (int i = 0; i < 600; i++) rand_cycle();
    // asynchronous reset in mid-cycle
    id_stall = 0; bu_fl = 0; st_fl = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_pc", pd_pc, 32'h200);
    chk("arst_instr", pd_instr, 32'h13);
    chk("arst_bubble", pd_bubble, 1'b1);
    chk("arst_stall", pd_stall, 1'b0);
    chk("arst_rsb_pc", pd_rsb_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 150; i++) rand_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/riscv_pd_rsbq.md
Name: riscv_pd_rsbq

Overview:
Second-generation instruction pre-decode stage, between IF and ID.
- Statically predicts JAL, JALR and conditional branches, and drives the early next-PC redirect to IF.
- Integrates a parametrised circular return-stack buffer (RSB) with saturating occupancy and overwrite-on-full.
- Replaces the fixed two-cycle CSR-write stall with a programmable stall counter.

Parameters:
XLEN, 32, datapath/PC width.
PC_INIT, 'h200, reset PC presented on pd_pc_o.
HAS_RVC, 0, 1: PC mask clears bit 0, 16-bit link increment allowed; 0: mask clears bits 1:0.
HAS_BPU, 0, 1: use bp_predict_i for branches; 0: BTFN (backward taken, forward not taken).
RSB_DEPTH, 4, RSB entries, 0 = no RSB; otherwise power of two, 2..64.
CSR_STALL_CYCLES, 2, bubbles inserted after a CSR write, 1..15.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
id_stall_i  in  1  ID stage stall.
du_mode_i  in  1  debug mode; suppresses all prediction and RSB updates.
bu_flush_i  in  1  branch-unit flush.
st_flush_i  in  1  state/CSR flush; has priority over bu_flush_i.
bu_nxt_pc_i  in  XLEN  PC loaded on bu_flush_i.
st_nxt_pc_i  in  XLEN  PC loaded on st_flush_i.
if_pc_i  in  XLEN  IF instruction PC.
if_instr_i  in  32  IF instruction.
if_bubble_i  in  1  IF instruction is invalid.
bp_predict_i  in  2  BPU 2-bit counter.
pd_stall_o  out  1  stall request to IF.
pd_flush_o  out  1  bu_flush_i | st_flush_i.
pd_pc_o  out  XLEN  registered PC.
pd_instr_o  out  32  registered instruction.
pd_bubble_o  out  1  registered bubble.
pd_bp_predict_o  out  2  registered prediction, pushed down the pipe.
pd_rsb_pc_o  out  XLEN  registered RSB top-of-stack.
pd_nxt_pc_o  out  XLEN  combinational predicted target.
pd_latch_nxt_pc_o  out  1  combinational redirect strobe.

Behaviour:
Interface: one clock clk_i; reset rst_ni is asynchronous and active-low.

Reset values:
- pd_pc_o = PC_INIT & mask; pd_instr_o = 32'h0000_0013 (NOP); pd_bubble_o = 1.
- pd_bp_predict_o = 0; pd_rsb_pc_o = 0.
- Stall counter = 0; RSB pointer = 0; RSB count = 0.

Pipeline register:
- pd_instr_o captures when !id_stall_i.
- pd_pc_o priority: st_flush_i -> st_nxt_pc_i; else bu_flush_i -> bu_nxt_pc_i; else !pd_stall_o -> if_pc_i. All values masked.
- pd_bubble_o = 1 on flush, or on capture while stall counter != 0; otherwise if_bubble_i on capture.
- Latency IF -> PD is 1 cycle.

CSR stall counter (4 bit):
- Trigger: non-bubble CSRRW/CSRRWI; CSRRS/CSRRC with rs1 != 0; CSRRSI/CSRRCI with uimm != 0.
- Load: trigger with counter == 0 and !id_stall_i loads CSR_STALL_CYCLES.
- Count: decrements by 1 per cycle with !id_stall_i while nonzero; holds under id_stall_i.
- pd_stall_o = id_stall_i | (counter != 0).
- Any flush clears the counter in the same cycle.

Prediction (du_mode_i = 0 and if_bubble_i = 0):
- JAL: taken; target = if_pc_i + sext(immUJ); prediction 2'b10.
- BRANCH: taken = bp_predict_i[1] if HAS_BPU, else immSB sign bit; target = if_pc_i + sext(immSB); prediction = bp_predict_i, or {sign, 0}.
- JALR: taken only when the decoded action includes pop and the RSB is non-empty; target = RSB top; prediction 2'b00.
- Otherwise: not taken, pd_nxt_pc_o = don't-care.

Redirect strobe:
- pd_latch_nxt_pc_o = taken & ~stalled_q & ~pd_flush_o.
- stalled_q is registered from (taken & id_stall_i).

RSB decode (link register = x1 or x5):
- rd link only -> push.
- rs1 link only -> pop.
- Both link, rs1 != rd -> pop then push (replace top).
- Both link, rs1 == rd -> push.
- Applies to JAL and JALR only.

RSB update (only when !pd_stall_o, no flush, not du_mode_i):
- Push: ptr += 1 (modulo DEPTH); write link PC to mem[ptr]; count = min(count + 1, DEPTH). Full push silently overwrites the oldest entry.
- Pop: ptr -= 1 modulo DEPTH; count -= 1. Pop when empty: no state change.
- Replace: write mem[ptr]; ptr unchanged; count = max(count, 1).
- Link PC = if_pc_i + 2 for a 16-bit instruction (HAS_RVC only), else if_pc_i + 4. Arithmetic is modulo 2^XLEN.
- pd_rsb_pc_o captures mem[ptr] when !pd_stall_o; captures 0 when RSB_DEPTH = 0.

Reset mid-operation: all state returns to reset values asynchronously; RSB memory content is don't-care.

Optional Feature:
RV12_PD_RSB_FLUSH_CLEAR_EN.
- Defined: st_flush_i also zeroes RSB count and pointer (trap/xRET entry invalidates return predictions).
- Undefined: RSB state is preserved across all flushes.

Test Plan:
1. Reset; release with IF bubble -> pd_pc_o = 'h200, pd_instr_o = 32'h00000013, pd_bubble_o = 1, pd_latch_nxt_pc_o = 0.
2. CSRRW x0,mstatus,x5 at PC 'h300, CSR_STALL_CYCLES = 3 -> pd_stall_o high exactly 3 cycles, 3 bubbles follow the CSR instruction; CSRRS with rs1 = x0 -> no stall.
3. JAL x1,+0x40 at 'h1000, then JALR x0,0(x1) -> push 'h1004; JALR predicted taken to 'h1004; count 1 -> 0.
4. RSB_DEPTH = 4, six nested JAL ra calls, then six returns -> first 4 pops predict the last 4 link PCs in LIFO order; pops 5-6 not taken, count stays 0.
5. BEQ imm = -8 at 'h2000, HAS_BPU = 0 -> taken, pd_nxt_pc_o = 'h1FF8, pd_bp_predict_o = 2'b10; imm = +8 -> not taken, 2'b00; under id_stall_i for 3 cycles the strobe pulses once only.
6. st_flush_i and bu_flush_i together, st_nxt_pc_i = 'h80 -> pd_pc_o = 'h80, pd_bubble_o = 1, stall counter cleared; with RV12_PD_RSB_FLUSH_CLEAR_EN the next JALR ret is not taken.
